// File: rtl/operand_loader.sv
// Sequences five captured nibbles onto holder with one-hot PB strobes.
// Define LOADER_GAP_EN to insert one all-low cycle between strobes.
module operand_loader #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [19:0] operands,
  output logic        PB1,
  output logic        PB2,
  output logic        PB3,
  output logic        PB4,
  output logic        PB5,
  output logic [3:0]  holder,
  output logic        busy,
  output logic        done,
  output logic [6:0]  expected_sum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
`ifdef LOADER_GAP_EN
    GAP   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [19:0] ops_q, ops_d;
  logic [6:0]  sum_q, sum_d;
  logic [4:0]  pb_q, pb_d;
  logic [3:0]  hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [3:0] nib(
    input logic [19:0] o,
    input logic [2:0]  i
  );
    case (i)
      3'd0:    nib = o[3:0];
      3'd1:    nib = o[7:4];
      3'd2:    nib = o[11:8];
      3'd3:    nib = o[15:12];
      3'd4:    nib = o[19:16];
      default: nib = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ops_q   <= '0;
      sum_q   <= '0;
      pb_q    <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      sum_q   <= sum_d;
      pb_q    <= pb_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          ops_d   = operands;
          sum_d   = 7'd0;
        end
      end
      DRIVE: begin
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          sum_d = sum_q + {3'b000, nib(ops_q, idx_q)};
          if (idx_q == 3'd4) begin
            state_d = DONE;
          end else begin
`ifdef LOADER_GAP_EN
            state_d = GAP;
`else
            idx_d   = idx_q + 3'd1;
`endif
          end
        end
      end
`ifdef LOADER_GAP_EN
      GAP: begin
        state_d = DRIVE;
        idx_d   = idx_q + 3'd1;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so they register alongside it.
  always_comb begin
    pb_d   = 5'd0;
    hold_d = 4'd0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (1'b1)
      (state_d == DRIVE): begin
        busy_d = 1'b1;
        hold_d = nib(ops_d, idx_d);
        pb_d   = 5'd1 << idx_d;
      end
`ifdef LOADER_GAP_EN
      (state_d == GAP): busy_d = 1'b1;
`endif
      (state_d == DONE): done_d = 1'b1;
      default: ;
    endcase
  end

  assign PB1          = pb_q[0];
  assign PB2          = pb_q[1];
  assign PB3          = pb_q[2];
  assign PB4          = pb_q[3];
  assign PB5          = pb_q[4];
  assign holder       = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign expected_sum = sum_q;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader at two hold lengths.
// Expected per-cycle outputs are queued at start and popped each cycle.
module tb_operand_loader;

`ifdef LOADER_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  localparam int H0 = 1;
  localparam int H1 = 3;

  typedef struct packed {
    logic [4:0] pb;
    logic [3:0] holder;
    logic       busy;
    logic       done;
    logic [6:0] sum;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  start;
  logic [19:0] operands;
  logic [4:0]  pb0, pb1;
  logic [3:0]  hl0, hl1;
  logic        bz0, bz1, dn0, dn1;
  logic [6:0]  sm0, sm1;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  operand_loader #(.HOLD_CYCLES(H0)) u0 (
    .clk(clk), .reset(reset), .start(start[0]),
    .operands(operands),
    .PB1(pb0[0]), .PB2(pb0[1]), .PB3(pb0[2]),
    .PB4(pb0[3]), .PB5(pb0[4]),
    .holder(hl0), .busy(bz0), .done(dn0),
    .expected_sum(sm0)
  );

  operand_loader #(.HOLD_CYCLES(H1)) u1 (
    .clk(clk), .reset(reset), .start(start[1]),
    .operands(operands),
    .PB1(pb1[0]), .PB2(pb1[1]), .PB3(pb1[2]),
    .PB4(pb1[3]), .PB5(pb1[4]),
    .holder(hl1), .busy(bz1), .done(dn1),
    .expected_sum(sm1)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample(input int u);
    obs_t o;
    if (u == 0) o = '{pb0, hl0, bz0, dn0, sm0};
    else        o = '{pb1, hl1, bz1, dn1, sm1};
    return o;
  endfunction

  function automatic int hold_of(input int u);
    return (u == 0) ? H0 : H1;
  endfunction

  // Builds the full expected trace; returns the final sum.
  function automatic logic [6:0] push_seq(
    input int          u,
    input logic [19:0] ops
  );
    logic [6:0] s = 7'd0;
    logic [3:0] nb;
    for (int n = 0; n < 5; n++) begin
      nb = ops[n*4 +: 4];
      for (int h = 0; h < hold_of(u); h++)
        sb.push_back('{5'(1 << n), nb, 1'b1, 1'b0, s});
      s = s + {3'b000, nb};
      if (GAP && n < 4)
        sb.push_back('{5'd0, 4'd0, 1'b1, 1'b0, s});
    end
    sb.push_back('{5'd0, 4'd0, 1'b0, 1'b1, s});
    sb.push_back('{5'd0, 4'd0, 1'b0, 1'b0, s});
    sb.push_back('{5'd0, 4'd0, 1'b0, 1'b0, s});
    return s;
  endfunction

  // mode 0: plain, 1: restart and operand change mid-run, 2: reset at PB3
  task automatic run_seq(
    input int          u,
    input logic [19:0] ops,
    input int          mode
  );
    obs_t       exp;
    logic [6:0] fin;
    int         len, c;
    bit         hit;
    string      tag;
    tag = $sformatf("u%0d_m%0d_%h", u, mode, ops);
    operands = ops;
    start[u] = 1'b1;
    @(posedge clk);
    #1;
    start[u] = 1'b0;
    fin = push_seq(u, ops);
    len = sb.size();
    c = 0;
    hit = 1'b0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      check($sformatf("%s_c%0d", tag, c), 32'(sample(u)), 32'(exp));
      reset = 1'b0;
      start[u] = 1'b0;
      if (mode == 1 && (c == 1 || c == len - 3)) begin
        start[u] = 1'b1;
        operands = ~ops;
      end
      if (mode == 2 && !hit && exp.pb == 5'b00100) begin
        hit = 1'b1;
        reset = 1'b1;
        sb.delete();
        sb.push_back('{5'd0, 4'd0, 1'b0, 1'b0, 7'd0});
        sb.push_back('{5'd0, 4'd0, 1'b0, 1'b0, 7'd0});
      end
      c++;
      if (sb.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
    start[u] = 1'b0;
    reset = 1'b0;
    if (mode != 2)
      check({tag, "_sum"}, 32'(sample(u).sum), 32'(fin));
  endtask

  initial begin
    reset = 1'b1;
    start = 2'b00;
    operands = 20'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_u0", 32'(sample(0)), 32'd0);
    check("rst_u1", 32'(sample(1)), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int u = 0; u < 2; u++) begin
      run_seq(u, 20'h32154, 0);
      run_seq(u, 20'hFFFFF, 0);
      run_seq(u, 20'h0A5C3, 1);
      run_seq(u, 20'h98765, 2);
      run_seq(u, 20'h12345, 0);
      run_seq(u, 20'($urandom), 0);
    end

    reset = 1'b1;
    start = 2'b11;
    operands = 20'hABCDE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 2'b00;
    check("rs_u0", 32'(sample(0)), 32'd0);
    check("rs_u1", 32'(sample(1)), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rs_idle_u0", 32'(sample(0)), 32'd0);
    check("rs_idle_u1", 32'(sample(1)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
